uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (uart.reg_dat_di/reg_dat_we/tx_busy) between NUM_REQ byte sources.
//  Typical sources: CPU MMIO path, debug monitor, loopback echo.
//  Round-robin arbitration per packet; a packet is a run of bytes ending in a byte with req_last=1.
//  A granted packet is never interleaved with another source's bytes.
//  A lock timeout recovers from a source that stalls mid-packet. Sits between the sources and the uart instance.
// PARAMETERS
//  NUM_REQ       2     number of requesters (2..8); GW = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1
//  BUSY_LAT      2     cycles after reg_dat_we pulse before tx_busy is trusted (>=1)
//  LOCK_TIMEOUT  1024  idle cycles with owner !valid while locked before lock is dropped (>=1)
// PORTS
//  clk           in   1          system clock (100 MHz)
//  rst           in   1          asynchronous reset, active-high
//  req_valid     in   NUM_REQ    per-source byte valid
//  req_data      in   8*NUM_REQ  per-source byte; source i uses [8*i+7:8*i]
//  req_last      in   NUM_REQ    per-source: this byte ends the packet
//  req_ready     out  NUM_REQ    per-source accept; transfer when valid&ready
//  uart_dat_di   out  8          byte to uart reg_dat_di
//  uart_dat_we   out  1          one-cycle write strobe to uart reg_dat_we
//  uart_tx_busy  in   1          uart transmitter busy
//  grant_id      out  GW         index of the last accepted source
//  locked        out  1          a packet is in progress; only grant_id may win
//  lock_abort    out  1          one-cycle pulse when the lock is dropped by timeout
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. uart_dat_we=0, uart_dat_di=0, req_ready=0, grant_id=0,
//   locked=0, lock_abort=0, rr_ptr=NUM_REQ-1 (source 0 has first priority), timeout counter=0.
//  States: IDLE -> ISSUE -> SETTLE -> DRAIN -> IDLE.
//  IDLE:
//   - winner = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//   - If locked, winner is grant_id only, and only when its valid is high.
//   - req_ready[winner] = 1 combinationally iff state==IDLE && !uart_tx_busy && a winner exists.
//     All other ready bits are 0. At most one ready bit is high at any time.
//   - On transfer, in the same edge:
//     - latch byte into uart_dat_di; grant_id<=winner; rr_ptr<=winner.
//     - locked<=~req_last[winner]; clear timeout counter; go to ISSUE.
//  ISSUE: uart_dat_we=1 for exactly this cycle; go to SETTLE.
//  SETTLE: wait BUSY_LAT cycles, ignoring tx_busy; go to DRAIN.
//  DRAIN: stay while uart_tx_busy=1; when 0, go to IDLE.
//  Latency: byte accepted at edge N -> uart_dat_we high in cycle N+1.
//   Minimum accept-to-accept spacing is 3+BUSY_LAT cycles even when tx_busy never rises.
//  uart_dat_di holds its value from acceptance until the next acceptance; it is stable during the we pulse.
//  Lock timeout:
//   - Counts only in IDLE while locked && !req_valid[grant_id].
//   - Counter reaching LOCK_TIMEOUT-1 -> next edge: locked<=0, lock_abort=1 for one cycle, counter<=0.
//   - Arbitration resumes in the following IDLE cycle.
//   - Counter resets whenever the owner's valid is high or the state leaves IDLE.
//  Simultaneous events:
//   - Several valids: the round-robin winner only.
//   - Owner valid in the same cycle as timeout expiry: the transfer wins; no abort.
//   - req_last=1 on the first byte: single-byte packet; locked stays 0.
//  uart_tx_busy high in IDLE (e.g. after reset mid-byte): no ready asserted until it falls.
//  req_valid may drop without a transfer; the arbiter holds no per-source state except the lock.
//  Reset mid-packet or mid-DRAIN: all state is cleared; a partially sent packet is not resumed.
// TESTING
//  1. Only req0 valid, byte 0x41, last=1, tx_busy low:
//     -> ready0 in the same cycle, we pulse next cycle with di=0x41, locked stays 0.
//  2. req0 and req1 both valid with single-byte packets 0xA0/0xB1, held:
//     -> order 0xA0, 0xB1, 0xA0, 0xB1; grant_id toggles 0,1,0,1.
//  3. req0 sends 3-byte packet 11,22,33 (last on 33) while req1 is continuously valid with 0x99:
//     -> uart sees 11,22,33,99; locked=1 from byte 11 acceptance until byte 33.
//  4. req0 sends 0x55 with last=0 then drops valid; req1 valid; LOCK_TIMEOUT=16:
//     -> lock_abort pulses after 16 idle cycles; next byte sent is req1's.
//  5. tx_busy modelled high for 10 cycles starting BUSY_LAT cycles after each we:
//     -> next ready no earlier than the cycle after busy falls; we never pulses while busy=1.
//  6. Assert rst during DRAIN with locked=1:
//     -> all outputs 0 immediately; after release, source 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART transmitter
// Sources are granted one byte per IDLE visit; an unfinished packet keeps the lock until its last byte or a timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_LAT     = 2,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_uart_dat_di,
  output logic                 o_uart_dat_we,
  input  logic                 i_uart_tx_busy,
  output logic [GW-1:0]        o_grant_id,
  output logic                 o_locked,
  output logic                 o_lock_abort
);

  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(BUSY_LAT - 1);
  localparam logic [GW-1:0] RR_INIT     = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [7:0]      r_dat_di;
  logic            r_locked;
  logic            r_lock_abort;
  logic [CW-1:0]   r_to_cnt;
  logic [SW-1:0]   r_settle_cnt;

  logic [GW-1:0]   w_winner;
  logic [GW-1:0]   w_hi;
  logic [GW-1:0]   w_lo;
  logic            w_hi_found;
  logic            w_lo_found;
  logic            w_found;
  logic            w_owner_valid;
  logic            w_xfer;
  logic            w_count;
  logic [7:0]      w_byte;
  logic            w_last;

  // Lowest valid index above rr_ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_lo       = GW'(i);
        w_lo_found = 1'b1;
        if (GW'(i) > r_rr_ptr) begin
          w_hi       = GW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_owner_valid = i_req_valid[r_grant_id];
    if (r_locked) begin
      w_found  = w_owner_valid;
      w_winner = r_grant_id;
    end else if (w_hi_found) begin
      w_found  = 1'b1;
      w_winner = w_hi;
    end else begin
      w_found  = w_lo_found;
      w_winner = w_lo;
    end
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == w_winner) begin
        w_byte = i_req_data[8*i +: 8];
      end
    end
    w_last = i_req_last[w_winner];
  end

  // Ready is held low while reset is asserted so no source sees a spurious accept.
  assign w_xfer  = (r_state == S_IDLE) && !i_uart_tx_busy && w_found && !i_rst;
  assign w_count = (r_state == S_IDLE) && r_locked && !w_owner_valid;

  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = w_xfer && (GW'(i) == w_winner);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next = S_DRAIN;
      S_DRAIN:  if (!i_uart_tx_busy) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_uart_dat_we = (r_state == S_ISSUE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr     <= RR_INIT;
      r_grant_id   <= '0;
      r_dat_di     <= '0;
      r_locked     <= 1'b0;
      r_lock_abort <= 1'b0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_lock_abort <= 1'b0;
      if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end else begin
        r_settle_cnt <= '0;
      end
      if (w_xfer) begin
        r_dat_di   <= w_byte;
        r_grant_id <= w_winner;
        r_rr_ptr   <= w_winner;
        r_locked   <= ~w_last;
        r_to_cnt   <= '0;
      end else if (w_count) begin
        if (r_to_cnt == TO_LAST) begin
          r_locked     <= 1'b0;
          r_lock_abort <= 1'b1;
          r_to_cnt     <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_uart_dat_di = r_dat_di;
  assign o_grant_id    = r_grant_id;
  assign o_locked      = r_locked;
  assign o_lock_abort  = r_lock_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Queue-fed sources, a UART busy model, and a log-based reference check of every accepted byte.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int BL = 2;
  localparam int LT = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   o_req_ready;
  logic [7:0]      o_uart_dat_di;
  logic            o_uart_dat_we;
  logic            busy;
  logic [GW-1:0]   o_grant_id;
  logic            o_locked;
  logic            o_lock_abort;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_LAT(BL), .LOCK_TIMEOUT(LT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(o_req_ready),
    .o_uart_dat_di(o_uart_dat_di), .o_uart_dat_we(o_uart_dat_we),
    .i_uart_tx_busy(busy),
    .o_grant_id(o_grant_id), .o_locked(o_locked), .o_lock_abort(o_lock_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    int            src;
    logic [7:0]    data;
    logic          last;
    logic [NR-1:0] vld;
  } acc_t;
  typedef struct {
    int            cyc;
    logic [7:0]    di;
    logic [GW-1:0] gid;
    logic          lck;
  } we_t;

  acc_t acc_q[$];
  we_t  we_q[$];
  int   abort_q[$];
  int   bad_onehot = 0;
  int   bad_we_busy = 0;
  int   bad_rdy_busy = 0;
  logic [NR-1:0] xfer_mask = '0;

  logic [8:0] src_q [NR][$];
  int   rd_idx [NR];
  int   stall_run [NR];
  int   flush_gen = 0;
  int   busy_mode = 0;
  logic busy_force = 1'b0;
  logic stall_en = 1'b0;

  // Monitor: logs acceptances, write strobes and aborts at the falling edge.
  initial begin : monitor
    acc_t a;
    we_t  w;
    forever begin
      @(negedge clk);
      xfer_mask = o_req_ready & req_valid;
      if ($countones(o_req_ready) > 1) bad_onehot++;
      if (o_uart_dat_we && busy) bad_we_busy++;
      if ((o_req_ready != '0) && busy) bad_rdy_busy++;
      if (xfer_mask != '0) begin
        a.src = 0;
        for (int i = 0; i < NR; i++) if (xfer_mask[i]) a.src = i;
        a.cyc  = cyc;
        a.data = req_data[8*a.src +: 8];
        a.last = req_last[a.src];
        a.vld  = req_valid;
        acc_q.push_back(a);
      end
      if (o_uart_dat_we) begin
        w.cyc = cyc; w.di = o_uart_dat_di; w.gid = o_grant_id; w.lck = o_locked;
        we_q.push_back(w);
      end
      if (o_lock_abort) abort_q.push_back(cyc);
    end
  end

  // Driver: presents the head of each source queue and models uart busy.
  initial begin : driver
    int seen_gen;
    int bstart;
    int blen;
    bit stl;
    seen_gen = 0; bstart = -100; blen = 0;
    req_valid = '0; req_data = '0; req_last = '0; busy = 1'b0;
    for (int i = 0; i < NR; i++) begin rd_idx[i] = 0; stall_run[i] = 0; end
    forever begin
      @(posedge clk); #1;
      if (flush_gen != seen_gen) begin
        seen_gen = flush_gen;
        for (int i = 0; i < NR; i++) rd_idx[i] = src_q[i].size();
      end else begin
        for (int i = 0; i < NR; i++) if (xfer_mask[i]) rd_idx[i]++;
      end
      for (int i = 0; i < NR; i++) begin
        stl = stall_en && (stall_run[i] < 3) && ($urandom_range(0, 3) == 0);
        if ((rd_idx[i] < src_q[i].size()) && !stl) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = src_q[i][rd_idx[i]][7:0];
          req_last[i]       = src_q[i][rd_idx[i]][8];
          stall_run[i]      = 0;
        end else begin
          req_valid[i] = 1'b0;
          if (stl) stall_run[i]++;
          else stall_run[i] = 0;
        end
      end
      if (o_uart_dat_we) begin
        bstart = cyc + BL;
        blen   = (busy_mode == 1) ? 10 : $urandom_range(0, 5);
      end
      if (busy_mode == 0) busy = busy_force;
      else busy = (cyc >= bstart) && (cyc < bstart + blen);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_next(input logic [NR-1:0] vld, input int rr);
    for (int k = 1; k <= NR; k++) begin
      if (vld[(rr + k) % NR]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    flush_gen++;
    busy_mode = 0; busy_force = 1'b0; stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    int n;
    bit pend;
    n = 0;
    do begin
      pend = 0;
      for (int i = 0; i < NR; i++) if (rd_idx[i] < src_q[i].size()) pend = 1;
      if (pend) begin @(posedge clk); #2; n++; end
    end while (pend && n < max_cyc);
    ok = !pend;
    repeat (20) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_q[0].push_back({1'b1, 8'h41});
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({o_uart_dat_we, o_uart_dat_di} !== 9'h0) begin
      n_bad++; $display("FAIL reset_dat: got %h want 000", {o_uart_dat_we, o_uart_dat_di});
    end
    n_cmp++;
    if ({o_req_ready, o_grant_id, o_locked, o_lock_abort} !== '0) begin
      n_bad++; $display("FAIL reset_ctl: ready=%b gid=%0d lck=%b abort=%b want all 0",
                        o_req_ready, o_grant_id, o_locked, o_lock_abort);
    end
    do_reset();
  endtask

  task automatic test_single();
    int ba, bw, t0;
    bit ok;
    do_reset();
    ba = acc_q.size(); bw = we_q.size(); t0 = cyc;
    src_q[0].push_back({1'b1, 8'h41});
    wait_drain(200, ok);
    n_cmp++;
    if (!ok || acc_q.size() != ba + 1 || we_q.size() != bw + 1) begin
      n_bad++; $display("FAIL t1_count: acc=%0d we=%0d want 1 1", acc_q.size() - ba, we_q.size() - bw);
    end else begin
      n_cmp++;
      if (acc_q[ba].cyc != t0 + 1 || acc_q[ba].src != 0) begin
        n_bad++; $display("FAIL t1_accept: cyc=%0d src=%0d want %0d 0", acc_q[ba].cyc, acc_q[ba].src, t0 + 1);
      end
      n_cmp++;
      if (we_q[bw].cyc != acc_q[ba].cyc + 1 || we_q[bw].di !== 8'h41) begin
        n_bad++; $display("FAIL t1_we: cyc=%0d di=%h want %0d 41", we_q[bw].cyc, we_q[bw].di, acc_q[ba].cyc + 1);
      end
      n_cmp++;
      if (we_q[bw].lck !== 1'b0 || o_locked !== 1'b0) begin
        n_bad++; $display("FAIL t1_locked: got %b/%b want 0", we_q[bw].lck, o_locked);
      end
    end
  endtask

  task automatic test_round_robin();
    int bw;
    bit ok;
    logic [7:0] exp_di [4];
    logic [GW-1:0] exp_g [4];
    exp_di = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
    exp_g  = '{2'd0, 2'd1, 2'd0, 2'd1};
    do_reset();
    bw = we_q.size();
    src_q[0].push_back({1'b1, 8'hA0}); src_q[0].push_back({1'b1, 8'hA0});
    src_q[1].push_back({1'b1, 8'hB1}); src_q[1].push_back({1'b1, 8'hB1});
    wait_drain(300, ok);
    n_cmp++;
    if (!ok || we_q.size() != bw + 4) begin
      n_bad++; $display("FAIL t2_count: we=%0d want 4", we_q.size() - bw);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (we_q[bw+k].di !== exp_di[k] || we_q[bw+k].gid !== exp_g[k]) begin
          n_bad++; $display("FAIL t2_order[%0d]: di=%h gid=%0d want %h %0d", k, we_q[bw+k].di, we_q[bw+k].gid, exp_di[k], exp_g[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (we_q[bw+k].cyc - we_q[bw+k-1].cyc != 3 + BL) begin
            n_bad++; $display("FAIL t2_spacing[%0d]: got %0d want %0d", k, we_q[bw+k].cyc - we_q[bw+k-1].cyc, 3 + BL);
          end
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    int bw;
    bit ok;
    logic [7:0] exp_di [4];
    logic exp_l [4];
    exp_di = '{8'h11, 8'h22, 8'h33, 8'h99};
    exp_l  = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    bw = we_q.size();
    src_q[0].push_back({1'b0, 8'h11}); src_q[0].push_back({1'b0, 8'h22}); src_q[0].push_back({1'b1, 8'h33});
    src_q[1].push_back({1'b1, 8'h99});
    wait_drain(300, ok);
    n_cmp++;
    if (!ok || we_q.size() != bw + 4) begin
      n_bad++; $display("FAIL t3_count: we=%0d want 4", we_q.size() - bw);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (we_q[bw+k].di !== exp_di[k] || we_q[bw+k].lck !== exp_l[k]) begin
          n_bad++; $display("FAIL t3_pkt[%0d]: di=%h lck=%b want %h %b", k, we_q[bw+k].di, we_q[bw+k].lck, exp_di[k], exp_l[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int ba, bw, bb, a, exp_ab;
    bit ok;
    do_reset();
    ba = acc_q.size(); bw = we_q.size(); bb = abort_q.size();
    src_q[0].push_back({1'b0, 8'h55});
    src_q[1].push_back({1'b1, 8'h77});
    wait_drain(300, ok);
    n_cmp++;
    if (!ok || acc_q.size() != ba + 2 || abort_q.size() != bb + 1 || we_q.size() != bw + 2) begin
      n_bad++; $display("FAIL t4_count: acc=%0d abort=%0d we=%0d want 2 1 2", acc_q.size() - ba, abort_q.size() - bb, we_q.size() - bw);
    end else begin
      a = acc_q[ba].cyc;
      exp_ab = a + 3 + BL + LT;
      n_cmp++;
      if (abort_q[bb] != exp_ab) begin
        n_bad++; $display("FAIL t4_abort_cyc: got %0d want %0d", abort_q[bb], exp_ab);
      end
      n_cmp++;
      if (acc_q[ba+1].src != 1 || acc_q[ba+1].cyc != exp_ab) begin
        n_bad++; $display("FAIL t4_next: src=%0d cyc=%0d want 1 %0d", acc_q[ba+1].src, acc_q[ba+1].cyc, exp_ab);
      end
      n_cmp++;
      if (we_q[bw+1].di !== 8'h77 || we_q[bw+1].gid !== 2'd1) begin
        n_bad++; $display("FAIL t4_byte: di=%h gid=%0d want 77 1", we_q[bw+1].di, we_q[bw+1].gid);
      end
    end
  endtask

  task automatic test_expiry_race();
    int ba, bb, a, n, target;
    bit ok;
    do_reset();
    ba = acc_q.size(); bb = abort_q.size();
    src_q[0].push_back({1'b0, 8'h5A});
    n = 0;
    while (acc_q.size() == ba && n < 100) begin @(posedge clk); #2; n++; end
    n_cmp++;
    if (acc_q.size() == ba) begin
      n_bad++; $display("FAIL t4b_first: no acceptance within %0d cycles", n);
    end else begin
      a = acc_q[ba].cyc;
      target = a + 3 + BL + LT - 2;
      while (cyc < target) begin @(posedge clk); #2; end
      src_q[0].push_back({1'b1, 8'h5B});
      wait_drain(200, ok);
      n_cmp++;
      if (abort_q.size() != bb) begin
        n_bad++; $display("FAIL t4b_abort: got %0d aborts want 0", abort_q.size() - bb);
      end
      n_cmp++;
      if (acc_q.size() != ba + 2 || acc_q[ba+1].cyc != target + 1 || acc_q[ba+1].data !== 8'h5B) begin
        n_bad++; $display("FAIL t4b_xfer: acc=%0d want 2 at cyc %0d data 5B", acc_q.size() - ba, target + 1);
      end
    end
  endtask

  task automatic test_busy();
    int ba, bw, b1, b2;
    bit ok;
    logic [7:0] exp_di [5];
    exp_di = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};
    do_reset();
    busy_mode = 1;
    ba = acc_q.size(); bw = we_q.size(); b1 = bad_we_busy; b2 = bad_rdy_busy;
    for (int k = 0; k < 3; k++) src_q[0].push_back({1'b1, 8'h10 + 8'(k)});
    for (int k = 0; k < 2; k++) src_q[1].push_back({1'b1, 8'h20 + 8'(k)});
    wait_drain(500, ok);
    n_cmp++;
    if (bad_we_busy != b1 || bad_rdy_busy != b2) begin
      n_bad++; $display("FAIL t5_busy: we_while_busy=%0d ready_while_busy=%0d want 0 0", bad_we_busy - b1, bad_rdy_busy - b2);
    end
    n_cmp++;
    if (!ok || acc_q.size() != ba + 5 || we_q.size() != bw + 5) begin
      n_bad++; $display("FAIL t5_count: acc=%0d we=%0d want 5 5", acc_q.size() - ba, we_q.size() - bw);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (we_q[bw+k].di !== exp_di[k]) begin
          n_bad++; $display("FAIL t5_order[%0d]: di=%h want %h", k, we_q[bw+k].di, exp_di[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (acc_q[ba+k].cyc != we_q[bw+k-1].cyc + BL + 10 + 1) begin
            n_bad++; $display("FAIL t5_gap[%0d]: accept cyc=%0d want %0d", k, acc_q[ba+k].cyc, we_q[bw+k-1].cyc + BL + 11);
          end
        end
      end
    end
    busy_mode = 0;
  endtask

  task automatic test_busy_idle();
    int ba, t;
    bit ok;
    do_reset();
    ba = acc_q.size();
    busy_force = 1'b1;
    src_q[1].push_back({1'b1, 8'hC3});
    repeat (10) @(posedge clk);
    #2;
    n_cmp++;
    if (acc_q.size() != ba || o_req_ready !== '0) begin
      n_bad++; $display("FAIL tb_idle_busy: acc=%0d ready=%b want 0 000", acc_q.size() - ba, o_req_ready);
    end
    t = cyc;
    busy_force = 1'b0;
    wait_drain(100, ok);
    n_cmp++;
    if (acc_q.size() != ba + 1 || acc_q[ba].cyc != t + 1 || acc_q[ba].src != 1) begin
      n_bad++; $display("FAIL tb_idle_release: acc=%0d want 1 at cyc %0d from src 1", acc_q.size() - ba, t + 1);
    end
  endtask

  task automatic test_reset_mid();
    int ba, n, a, t;
    bit ok;
    do_reset();
    busy_mode = 1;
    ba = acc_q.size();
    src_q[0].push_back({1'b0, 8'h12}); src_q[0].push_back({1'b1, 8'h34});
    src_q[1].push_back({1'b1, 8'h56});
    n = 0;
    while (acc_q.size() == ba && n < 100) begin @(posedge clk); #2; n++; end
    a = (acc_q.size() > ba) ? acc_q[ba].cyc : cyc;
    while (cyc < a + 6) begin @(posedge clk); #2; end
    n_cmp++;
    if (o_locked !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t6_pre: locked=%b busy=%b want 1 1", o_locked, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_uart_dat_we, o_uart_dat_di, o_req_ready, o_grant_id, o_locked, o_lock_abort} !== '0) begin
      n_bad++; $display("FAIL t6_async: we=%b di=%h ready=%b gid=%0d lck=%b abort=%b want all 0",
                        o_uart_dat_we, o_uart_dat_di, o_req_ready, o_grant_id, o_locked, o_lock_abort);
    end
    flush_gen++;
    busy_mode = 0; busy_force = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    ba = acc_q.size(); t = cyc;
    src_q[0].push_back({1'b1, 8'h66});
    src_q[1].push_back({1'b1, 8'h77});
    wait_drain(200, ok);
    n_cmp++;
    if (acc_q.size() != ba + 2 || acc_q[ba].src != 0 || acc_q[ba].data !== 8'h66 || acc_q[ba].cyc != t + 1) begin
      n_bad++; $display("FAIL t6_after: acc=%0d first src=%0d want 2, src 0 data 66 at cyc %0d", acc_q.size() - ba, (acc_q.size() > ba) ? acc_q[ba].src : -1, t + 1);
    end
  endtask

  task automatic test_random();
    int ba, bw, bb, b0, total, m_rr, m_owner, exp_src, s;
    int p [NR];
    bit m_locked, ok;
    logic [8:0] exp_b;
    do_reset();
    busy_mode = 2; stall_en = 1'b1;
    ba = acc_q.size(); bw = we_q.size(); bb = abort_q.size(); b0 = bad_onehot + bad_we_busy + bad_rdy_busy;
    total = 0;
    for (int i = 0; i < NR; i++) begin
      int len;
      p[i] = src_q[i].size();
      for (int k = 0; k < 6; k++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          src_q[i].push_back({(b == len - 1), 8'($urandom)});
          total++;
        end
      end
    end
    wait_drain(4000, ok);
    busy_mode = 0; stall_en = 1'b0;
    n_cmp++;
    if (!ok || acc_q.size() != ba + total || we_q.size() != bw + total || abort_q.size() != bb) begin
      n_bad++; $display("FAIL rnd_count: acc=%0d we=%0d abort=%0d want %0d %0d 0", acc_q.size() - ba, we_q.size() - bw, abort_q.size() - bb, total, total);
    end else begin
      m_rr = NR - 1; m_owner = 0; m_locked = 0;
      for (int k = 0; k < total; k++) begin
        s = acc_q[ba+k].src;
        exp_src = m_locked ? m_owner : rr_next(acc_q[ba+k].vld, m_rr);
        n_cmp++;
        if (s != exp_src) begin
          n_bad++; $display("FAIL rnd_winner[%0d]: src=%0d want %0d (vld=%b)", k, s, exp_src, acc_q[ba+k].vld);
        end
        exp_b = src_q[s][p[s]];
        p[s]++;
        n_cmp++;
        if ({acc_q[ba+k].last, acc_q[ba+k].data} !== exp_b) begin
          n_bad++; $display("FAIL rnd_byte[%0d]: got %h want %h", k, {acc_q[ba+k].last, acc_q[ba+k].data}, exp_b);
        end
        n_cmp++;
        if (we_q[bw+k].cyc != acc_q[ba+k].cyc + 1 || we_q[bw+k].di !== acc_q[ba+k].data) begin
          n_bad++; $display("FAIL rnd_we[%0d]: cyc=%0d di=%h want %0d %h", k, we_q[bw+k].cyc, we_q[bw+k].di, acc_q[ba+k].cyc + 1, acc_q[ba+k].data);
        end
        if (k > 0) begin
          n_cmp++;
          if (acc_q[ba+k].cyc - acc_q[ba+k-1].cyc < 3 + BL) begin
            n_bad++; $display("FAIL rnd_spacing[%0d]: got %0d want >= %0d", k, acc_q[ba+k].cyc - acc_q[ba+k-1].cyc, 3 + BL);
          end
        end
        m_rr = s; m_owner = s; m_locked = !acc_q[ba+k].last;
      end
    end
    n_cmp++;
    if (bad_onehot + bad_we_busy + bad_rdy_busy != b0) begin
      n_bad++; $display("FAIL rnd_invariants: onehot=%0d we_busy=%0d rdy_busy=%0d new violations", bad_onehot, bad_we_busy, bad_rdy_busy);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_expiry_race();
    test_busy();
    test_busy_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
